// File: rtl/key_pkg.sv
// Shared types and default timing constants for the push-button front end.
package key_pkg;

  // Per-channel debounce/repeat state.
  typedef enum logic [1:0] {
    KS_IDLE,
    KS_PRESS_WAIT,
    KS_HELD,
    KS_RELEASE_WAIT
  } key_state_t;

  // Defaults for a 50 MHz system clock.
  localparam int unsigned DEF_N_KEYS               = 4;
  localparam int unsigned DEF_DEBOUNCE_CYCLES      = 500_000;     // 10 ms
  localparam int unsigned DEF_REPEAT_DELAY_CYCLES  = 25_000_000;  // 500 ms
  localparam int unsigned DEF_REPEAT_PERIOD_CYCLES = 5_000_000;   // 100 ms

endpackage

// File: rtl/key_debounce_channel.sv
// One key channel: two-flop synchronizer, debounce/hold FSM, debounce and
// auto-repeat counters, registered event outputs.
module key_debounce_channel
  import key_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES      = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned REPEAT_DELAY_CYCLES  = DEF_REPEAT_DELAY_CYCLES,
  parameter int unsigned REPEAT_PERIOD_CYCLES = DEF_REPEAT_PERIOD_CYCLES,
  parameter logic        REPEAT_EN            = 1'b1
) (
  input  logic CLOCK_50_B5B,
  input  logic rst,
  input  logic key_n,
  output logic key_level,
  output logic key_press,
  output logic key_release,
  output logic key_repeat
);

  localparam int unsigned DB_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned RP_W = $clog2(REPEAT_DELAY_CYCLES + REPEAT_PERIOD_CYCLES + 1);

  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  // rp_cnt holds (elapsed hold cycles + REPEAT_PERIOD_CYCLES). The offset keeps
  // the reload point (delay - period) non-negative even when period > delay,
  // while pulse timing is identical to a zero-based counter.
  localparam logic [RP_W-1:0] RP_START  = RP_W'(REPEAT_PERIOD_CYCLES);
  localparam logic [RP_W-1:0] RP_FIRE   = RP_W'(REPEAT_DELAY_CYCLES + REPEAT_PERIOD_CYCLES - 1);
  localparam logic [RP_W-1:0] RP_RELOAD = RP_W'(REPEAT_DELAY_CYCLES);

  logic       sync1_q, sync2_q;
  logic       s;
  key_state_t state_q, state_d;
  logic [DB_W-1:0] db_q, db_d;
  logic [RP_W-1:0] rp_q, rp_d;
  logic level_d, press_d, release_d, repeat_d;

  // Two-flop synchronizer; resets to the released level.
  always_ff @(posedge CLOCK_50_B5B) begin
    if (rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= key_n;
      sync2_q <= sync1_q;
    end
  end

  assign s = ~sync2_q;

  // Next-state, counter and output decode.
  always_comb begin
    state_d   = state_q;
    db_d      = db_q;
    rp_d      = rp_q;
    level_d   = 1'b0;
    press_d   = 1'b0;
    release_d = 1'b0;
    repeat_d  = 1'b0;
    unique case (state_q)
      KS_IDLE: begin
        if (s) begin
          state_d = KS_PRESS_WAIT;
          db_d    = '0;
        end
      end
      KS_PRESS_WAIT: begin
        if (!s) begin
          state_d = KS_IDLE;
        end else if (db_q == DB_LAST) begin
          state_d  = KS_HELD;
          press_d  = 1'b1;
          repeat_d = 1'b1;
          rp_d     = RP_START;
        end else begin
          db_d = db_q + 1'b1;
        end
      end
      KS_HELD: begin
        if (REPEAT_EN) begin
          if (rp_q == RP_FIRE) begin
            repeat_d = 1'b1;
            rp_d     = RP_RELOAD;
          end else begin
            rp_d = rp_q + 1'b1;
          end
        end
        if (!s) begin
          state_d = KS_RELEASE_WAIT;
          db_d    = '0;
        end
      end
      KS_RELEASE_WAIT: begin
        if (s) begin
          state_d = KS_HELD;
        end else if (db_q == DB_LAST) begin
          state_d   = KS_IDLE;
          release_d = 1'b1;
        end else begin
          db_d = db_q + 1'b1;
        end
      end
      default: state_d = KS_IDLE;
    endcase
    level_d = (state_d == KS_HELD) || (state_d == KS_RELEASE_WAIT);
  end

  // State, counters and registered outputs.
  always_ff @(posedge CLOCK_50_B5B) begin
    if (rst) begin
      state_q     <= KS_IDLE;
      db_q        <= '0;
      rp_q        <= '0;
      key_level   <= 1'b0;
      key_press   <= 1'b0;
      key_release <= 1'b0;
      key_repeat  <= 1'b0;
    end else begin
      state_q     <= state_d;
      db_q        <= db_d;
      rp_q        <= rp_d;
      key_level   <= level_d;
      key_press   <= press_d;
      key_release <= release_d;
      key_repeat  <= repeat_d;
    end
  end

endmodule

// File: rtl/key_debouncer.sv
// Push-button front end: one independent debounce channel per key.
module key_debouncer
  import key_pkg::*;
#(
  parameter int unsigned       N_KEYS               = DEF_N_KEYS,
  parameter int unsigned       DEBOUNCE_CYCLES      = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned       REPEAT_DELAY_CYCLES  = DEF_REPEAT_DELAY_CYCLES,
  parameter int unsigned       REPEAT_PERIOD_CYCLES = DEF_REPEAT_PERIOD_CYCLES,
  parameter logic [N_KEYS-1:0] REPEAT_EN            = '1
) (
  input  logic              CLOCK_50_B5B,
  input  logic              rst,
  input  logic [N_KEYS-1:0] KEY_N,
  output logic [N_KEYS-1:0] key_level,
  output logic [N_KEYS-1:0] key_press,
  output logic [N_KEYS-1:0] key_release,
  output logic [N_KEYS-1:0] key_repeat
);

  // Channels run fully in parallel; no arbitration between keys.
  for (genvar i = 0; i < N_KEYS; i++) begin : g_key
    key_debounce_channel #(
      .DEBOUNCE_CYCLES      (DEBOUNCE_CYCLES),
      .REPEAT_DELAY_CYCLES  (REPEAT_DELAY_CYCLES),
      .REPEAT_PERIOD_CYCLES (REPEAT_PERIOD_CYCLES),
      .REPEAT_EN            (REPEAT_EN[i])
    ) u_chan (
      .CLOCK_50_B5B (CLOCK_50_B5B),
      .rst          (rst),
      .key_n        (KEY_N[i]),
      .key_level    (key_level[i]),
      .key_press    (key_press[i]),
      .key_release  (key_release[i]),
      .key_repeat   (key_repeat[i])
    );
  end

endmodule

// File: tb/tb_key_debouncer.sv
// Directed bench for key_debouncer (DEBOUNCE=4, DELAY=20, PERIOD=8, key 3
// auto-repeat disabled) plus a 1-key instance with DEBOUNCE=1.
module tb_key_debouncer;

  localparam int unsigned NK = 4;

  logic          CLOCK_50_B5B = 1'b0;
  logic          rst;
  logic [NK-1:0] KEY_N;
  logic [NK-1:0] key_level, key_press, key_release, key_repeat;

  logic [0:0] key1_n;
  logic [0:0] k1_level, k1_press, k1_release, k1_repeat;

  key_debouncer #(
    .N_KEYS               (4),
    .DEBOUNCE_CYCLES      (4),
    .REPEAT_DELAY_CYCLES  (20),
    .REPEAT_PERIOD_CYCLES (8),
    .REPEAT_EN            (4'b0111)
  ) dut (
    .CLOCK_50_B5B (CLOCK_50_B5B),
    .rst          (rst),
    .KEY_N        (KEY_N),
    .key_level    (key_level),
    .key_press    (key_press),
    .key_release  (key_release),
    .key_repeat   (key_repeat)
  );

  key_debouncer #(
    .N_KEYS               (1),
    .DEBOUNCE_CYCLES      (1),
    .REPEAT_DELAY_CYCLES  (3),
    .REPEAT_PERIOD_CYCLES (2),
    .REPEAT_EN            (1'b1)
  ) dut1 (
    .CLOCK_50_B5B (CLOCK_50_B5B),
    .rst          (rst),
    .KEY_N        (key1_n),
    .key_level    (k1_level),
    .key_press    (k1_press),
    .key_release  (k1_release),
    .key_repeat   (k1_repeat)
  );

  always #5 CLOCK_50_B5B = ~CLOCK_50_B5B;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int ev_q[$];
  int exp_q[$];
  int k1_press_n, k1_press_at, k1_rel_n, k1_rel_at, k1_rep_n;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Event code: kind (1 press, 2 release, 3 repeat), key, cycle.
  function automatic int ev(input int kind, input int key, input int c);
    return kind * 100000 + key * 10000 + c;
  endfunction

  // One clock edge; outputs sampled 1 time unit after it and logged.
  task automatic step();
    @(posedge CLOCK_50_B5B);
    cyc++;
    #1;
    for (int k = 0; k < NK; k++) begin
      if (key_press[k] === 1'b1)   ev_q.push_back(ev(1, k, cyc));
      if (key_release[k] === 1'b1) ev_q.push_back(ev(2, k, cyc));
      if (key_repeat[k] === 1'b1)  ev_q.push_back(ev(3, k, cyc));
    end
    if (k1_press[0] === 1'b1)   begin k1_press_n++; k1_press_at = cyc; end
    if (k1_release[0] === 1'b1) begin k1_rel_n++;   k1_rel_at = cyc;   end
    if (k1_repeat[0] === 1'b1)  k1_rep_n++;
  endtask

  task automatic do_reset(input string tag);
    rst    = 1'b1;
    KEY_N  = '1;
    key1_n = 1'b1;
    step();
    step();
    check({tag, "_rst_out"}, 32'({key_level, key_press, key_release, key_repeat}), 0);
    rst = 1'b0;
    cyc = 0;
    ev_q.delete();
    exp_q.delete();
  endtask

  task automatic compare_events(input string tag);
    ev_q.sort();
    exp_q.sort();
    check({tag, "_nev"}, ev_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < ev_q.size(); i++)
      check($sformatf("%s_ev%0d", tag, i), ev_q[i], exp_q[i]);
  endtask

  initial begin
    rst    = 1'b1;
    KEY_N  = '1;
    key1_n = 1'b1;

    // 1: clean press edges 10..19; second instance sees the same waveform.
    do_reset("t1");
    k1_press_n = 0; k1_rel_n = 0; k1_rep_n = 0; k1_press_at = 0; k1_rel_at = 0;
    for (int k = 1; k <= 40; k++) begin
      KEY_N  = '1;
      key1_n = 1'b1;
      if (k >= 10 && k < 20) begin
        KEY_N[0]  = 1'b0;
        key1_n[0] = 1'b0;
      end
      step();
      if (k == 15) check("t1_lvl15", key_level[0], 0);
      if (k == 16) check("t1_lvl16", key_level[0], 1);
      if (k == 25) check("t1_lvl25", key_level[0], 1);
      if (k == 26) check("t1_lvl26", key_level[0], 0);
      if (k == 14) check("db1_lvl14", k1_level[0], 1);
    end
    exp_q = '{ev(1, 0, 16), ev(3, 0, 16), ev(2, 0, 26)};
    compare_events("t1");
    check("db1_press_n", k1_press_n, 1);
    check("db1_press_at", k1_press_at, 13);
    check("db1_rel_n", k1_rel_n, 1);
    check("db1_rel_at", k1_rel_at, 23);
    check("db1_rep_n", k1_rep_n, 5);

    // 2: bounce (low 16..18, high 19) then stable low 20..35.
    do_reset("t2");
    for (int k = 1; k <= 50; k++) begin
      KEY_N = '1;
      if ((k >= 16 && k <= 18) || (k >= 20 && k <= 35)) KEY_N[0] = 1'b0;
      step();
      if (k == 25) check("t2_nopress25", key_press[0], 0);
    end
    exp_q = '{ev(1, 0, 26), ev(3, 0, 26), ev(2, 0, 42)};
    compare_events("t2");

    // 3: long hold, auto-repeat train.
    do_reset("t3");
    for (int k = 1; k <= 85; k++) begin
      KEY_N = '1;
      if (k >= 10 && k <= 70) KEY_N[0] = 1'b0;
      step();
      if (k == 74) check("t3_lvl74", key_level[0], 1);
    end
    exp_q = '{ev(1, 0, 16), ev(3, 0, 16), ev(3, 0, 36), ev(3, 0, 44), ev(3, 0, 52),
              ev(3, 0, 60), ev(3, 0, 68), ev(2, 0, 77)};
    compare_events("t3");

    // 4: 2-cycle glitch while held, then a real release.
    do_reset("t4");
    for (int k = 1; k <= 65; k++) begin
      KEY_N = '1;
      if ((k >= 10 && k <= 29) || (k >= 32 && k <= 49)) KEY_N[0] = 1'b0;
      step();
      if (k == 33) check("t4_lvl33", key_level[0], 1);
      if (k == 34) check("t4_lvl34", key_level[0], 1);
      if (k == 55) check("t4_lvl55", key_level[0], 1);
      if (k == 56) check("t4_lvl56", key_level[0], 0);
    end
    exp_q = '{ev(1, 0, 16), ev(3, 0, 16), ev(3, 0, 38), ev(3, 0, 46), ev(2, 0, 56)};
    compare_events("t4");

    // 5: keys 1 and 2 together.
    do_reset("t5");
    for (int k = 1; k <= 35; k++) begin
      KEY_N = '1;
      if (k >= 10 && k <= 20) begin
        KEY_N[1] = 1'b0;
        KEY_N[2] = 1'b0;
      end
      step();
      if (k == 16) check("t5_lvl16", 32'(key_level), 32'b0110);
    end
    exp_q = '{ev(1, 1, 16), ev(1, 2, 16), ev(3, 1, 16), ev(3, 2, 16),
              ev(2, 1, 27), ev(2, 2, 27)};
    compare_events("t5");

    // 6: reset pulse while key 3 (repeat disabled) is held.
    do_reset("t6");
    for (int k = 1; k <= 60; k++) begin
      KEY_N = '1;
      if (k >= 5) KEY_N[3] = 1'b0;
      rst = (k == 21);
      step();
      if (k == 20) check("t6_lvl20", key_level[3], 1);
      if (k == 21) check("t6_rst_out", 32'({key_level, key_press, key_release, key_repeat}), 0);
      if (k == 27) check("t6_nopress27", key_press[3], 0);
      if (k == 28) check("t6_lvl28", key_level[3], 1);
    end
    rst = 1'b0;
    exp_q = '{ev(1, 3, 11), ev(3, 3, 11), ev(1, 3, 28), ev(3, 3, 28)};
    compare_events("t6");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
